unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the CPU's instruction-fetch port and its data (load/store) port.
Grants one access at a time through a small FSM, holds the memory command for a fixed read latency, and returns the read data with a one-cycle valid pulse to the granted requester.
Sits between the CPU core and the memory, and replaces the separate instruction-memory and data-memory paths once the design moves to a multi-cycle core.

Parameters:
ADDR_W, 32, address width of both requesters and of the memory
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to mem_rdata valid; legal range 1..7, and 0 is unsupported

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch byte address; stable while if_req=1
if_rdata  out  DATA_W  fetched instruction; valid when if_valid=1
if_valid  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid when d_valid=1
d_valid  out  1  one-cycle completion pulse for data (load and store)
mem_en  out  1  memory command strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high while an access is outstanding

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, the state is IDLE, cnt is 0, and last_grant is FETCH.
- FSM states are IDLE, WAIT_IF and WAIT_D.
- IDLE, at a rising edge:
  - If d_req=1: load mem_addr/mem_we/mem_wdata from the data port, set mem_en<=1, cnt<=MEM_LAT, and go to WAIT_D.
  - Else if if_req=1: do the same from the fetch port with mem_we<=0, and go to WAIT_IF.
  - Else: stay in IDLE.
- Default arbitration is fixed priority: data wins, because the data access belongs to the older instruction.
- WAIT_x:
  - mem_en<=0 on the first edge after issue.
  - mem_addr, mem_we and mem_wdata hold their values until return to IDLE.
  - cnt decrements every edge.
  - On the edge where cnt==1: capture mem_rdata into if_rdata or d_rdata, pulse the matching valid for exactly one cycle, clear mem_we, and go to IDLE.
- Latency: a request sampled at edge E0 gives mem_en high during cycle E0..E1, and valid high during the cycle after edge E0+MEM_LAT. Total is MEM_LAT+1 cycles from request to valid, with no idle gap imposed between accesses.
- Stores: d_valid pulses as the ack, and d_rdata keeps its previous value.
- The rdata registers hold their value until the next completion on the same port.
- busy=1 in the WAIT states and 0 in IDLE. Valid cycles coincide with IDLE.
- Requester rule: drop req in the cycle its valid is high. A req still high at the next edge starts a new access, and this is intended for back-to-back fetch.
- If the arbiter is in IDLE with both requests at the same edge, only one is granted. The loser's request stays pending, with no loss and no duplicate.
- Changing if_addr or d_addr while the port is waiting has no effect, because the command was latched at issue.
- cnt is 3 bits wide and never wraps: MEM_LAT ≤ 7 is guaranteed by the parameter range.
- A reset asserted mid-access immediately clears all state and outputs. The in-flight memory result is discarded, and no valid is produced.
- Release of rst is synchronised externally. The first grant can occur at the first edge after rst goes high.

Optional Feature:
ARB_RR_EN
- Defined: when both requests are high in IDLE, the grant goes to the port that was not granted last. last_grant updates on every grant. With only one requester, that requester is granted regardless of last_grant.
- Undefined: fixed data-first priority, and last_grant is not implemented.

Test Plan:
1. MEM_LAT=1, if_req=1 with if_addr=0x00400000, memory returns 0x00000013 → mem_en is a single pulse, if_valid is high 2 cycles after the request, if_rdata=0x00000013, busy=1 for 1 cycle.
2. MEM_LAT=3, d_req with d_we=1, d_addr=0x10010004, d_wdata=0xDEADBEEF → one mem_en cycle with mem_we=1, mem_addr=0x10010004 and mem_wdata=0xDEADBEEF. d_valid pulses 4 cycles after the request, and d_rdata is unchanged.
3. if_req and d_req raised at the same edge (fixed priority) → data is granted first, and the fetch is issued at the edge after d_valid. Each valid pulses once. Total is 2×(MEM_LAT+1) cycles.
4. ARB_RR_EN defined, both requests held continuously for 4 accesses → grants alternate D, IF, D, IF.
5. rst pulled low 1 cycle after issue with MEM_LAT=3 → all outputs are 0 at once, and no valid appears after rst releases while the requests are low.
6. if_req held high continuously with MEM_LAT=1 → a new fetch issues every 2 cycles, and if_valid pulses every 2 cycles with the matching if_rdata.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Purpose:
//   Shares one single-port unified memory between a CPU instruction-fetch
//   port and a data (load/store) port. One access is granted at a time. The
//   memory command is held while the access is outstanding. Read data comes
//   back to the granted requester together with a one-cycle valid pulse.
//   Every output is driven straight from a register.
//
// Optional feature (compile-time macro):
//   ARB_RR_EN - when defined, simultaneous requests in IDLE are granted to
//               the port that was NOT granted last (round robin). When it is
//               undefined, arbitration is fixed data-first and there is no
//               last-grant register.
//
// Parameters:
//   ADDR_W  - address width of both requesters and of the memory
//   DATA_W  - data width
//   MEM_LAT - cycles from mem_en to mem_rdata valid, legal range 1..7
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   if_req     in   fetch request, held until if_valid
//   if_addr    in   fetch byte address
//   if_rdata   out  fetched instruction, valid with if_valid
//   if_valid   out  one-cycle fetch completion pulse
//   d_req      in   data request, held until d_valid
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data byte address
//   d_wdata    in   store data
//   d_rdata    out  load data, valid with d_valid (unchanged by stores)
//   d_valid    out  one-cycle data completion pulse (loads and stores)
//   mem_en     out  memory command strobe, one cycle per access
//   mem_we     out  memory write enable, qualified by mem_en
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid MEM_LAT cycles after mem_en
//   busy       out  high while an access is outstanding
// ----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // The latency counter is 3 bits wide, so only 1..7 can be represented.
  // A latency of 0 would need a combinational return path, which is
  // not provided.
  generate
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
      $error("unified_mem_arbiter: MEM_LAT must be in the range 1..7");
    end
  endgenerate

  localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IF = 2'd1,
    S_WAIT_D  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_next;

  logic                r_mem_en;
  logic                w_mem_en_next;
  logic                r_mem_we;
  logic                w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W-1:0]   w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   w_mem_wdata_next;

  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   w_if_rdata_next;
  logic                r_if_valid;
  logic                w_if_valid_next;
  logic [DATA_W-1:0]   r_d_rdata;
  logic [DATA_W-1:0]   w_d_rdata_next;
  logic                r_d_valid;
  logic                w_d_valid_next;
  logic                r_busy;
  logic                w_busy_next;

  logic                w_grant_d;
  logic                w_grant_if;
  logic                w_last_beat;

  // --------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE)
  // --------------------------------------------------------------------------
`ifdef ARB_RR_EN
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic r_last_grant;
  logic w_last_grant_next;

  // Data wins a tie only if fetch was the last port served. A lone
  // requester always wins, whatever the history.
  assign w_grant_d = d_req && (!if_req || (r_last_grant == GRANT_FETCH));

  always_comb begin
    w_last_grant_next = r_last_grant;
    if (r_state == S_IDLE) begin
      if (w_grant_d) begin
        w_last_grant_next = GRANT_DATA;
      end else if (w_grant_if) begin
        w_last_grant_next = GRANT_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GRANT_FETCH;
    end else begin
      r_last_grant <= w_last_grant_next;
    end
  end
`else
  // Fixed priority: the data access belongs to the older instruction.
  assign w_grant_d = d_req;
`endif

  assign w_grant_if = if_req && !w_grant_d;

  // The counter is loaded with MEM_LAT at issue, so a count of 1 marks the
  // edge on which mem_rdata is valid.
  assign w_last_beat = (r_cnt == 3'd1);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_next = S_WAIT_D;
        end else if (w_grant_if) begin
          w_state_next = S_WAIT_IF;
        end
      end
      S_WAIT_IF, S_WAIT_D: begin
        if (w_last_beat) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_next       = r_cnt;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_if_valid_next  = 1'b0;
    w_d_rdata_next   = r_d_rdata;
    w_d_valid_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_mem_en_next    = 1'b1;
          w_mem_we_next    = d_we;
          w_mem_addr_next  = d_addr;
          w_mem_wdata_next = d_wdata;
          w_cnt_next       = LAT_CNT;
        end else if (w_grant_if) begin
          w_mem_en_next    = 1'b1;
          w_mem_we_next    = 1'b0;
          w_mem_addr_next  = if_addr;
          w_cnt_next       = LAT_CNT;
        end
      end
      S_WAIT_IF, S_WAIT_D: begin
        // Address, write enable and write data stay latched from the issue
        // edge, so requester-side changes while waiting are ignored.
        w_cnt_next = r_cnt - 3'd1;
        if (w_last_beat) begin
          w_mem_we_next = 1'b0;
          if (r_state == S_WAIT_IF) begin
            w_if_rdata_next = mem_rdata;
            w_if_valid_next = 1'b1;
          end else begin
            // A store only acknowledges; d_rdata keeps the last load result.
            if (!r_mem_we) begin
              w_d_rdata_next = mem_rdata;
            end
            w_d_valid_next = 1'b1;
          end
        end
      end
      default: begin
        w_cnt_next = 3'd0;
      end
    endcase
  end

  // busy is registered alongside the state so it is high exactly in WAIT_x.
  assign w_busy_next = (w_state_next != S_IDLE);

  // --------------------------------------------------------------------------
  // Datapath / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 3'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_if_valid  <= w_if_valid_next;
      r_d_rdata   <= w_d_rdata_next;
      r_d_valid   <= w_d_valid_next;
      r_busy      <= w_busy_next;
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Two arbiter instances share one clock: instance 0 with MEM_LAT=1 and
// instance 1 with MEM_LAT=3. Each instance has a small memory model. That
// model drives mem_rdata only inside the cycle window the latency allows, and
// drives a poison value at all other times. Expected completions (port, data,
// cycle) go into a per-instance queue when a request is driven. They are
// popped when a valid pulse appears.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst       [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic [DW-1:0] if_rdata  [2];
  logic          if_valid  [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AW-1:0] d_addr    [2];
  logic [DW-1:0] d_wdata   [2];
  logic [DW-1:0] d_rdata   [2];
  logic          d_valid   [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 0) return 32'h0000_0013;
    return 32'hA500_0000 | 32'(idx * 32'h0001_0101);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = 2 * gi + 1;
    logic [31:0] mem [16];
    logic [2:0]  age;
    logic        data_window;

    unified_mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .MEM_LAT(LAT)
    ) dut (
      .clk      (clk),
      .rst      (rst[gi]),
      .if_req   (if_req[gi]),
      .if_addr  (if_addr[gi]),
      .if_rdata (if_rdata[gi]),
      .if_valid (if_valid[gi]),
      .d_req    (d_req[gi]),
      .d_we     (d_we[gi]),
      .d_addr   (d_addr[gi]),
      .d_wdata  (d_wdata[gi]),
      .d_rdata  (d_rdata[gi]),
      .d_valid  (d_valid[gi]),
      .mem_en   (mem_en[gi]),
      .mem_we   (mem_we[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi]),
      .busy     (busy[gi])
    );

    // age counts edges since the command cycle. Read data is presented only
    // in the cycle ending at issue edge + LAT.
    always @(posedge clk) begin
      if (!rst[gi]) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        age <= 3'd7;
      end else begin
        if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi][5:2]] <= mem_wdata[gi];
        if (mem_en[gi]) age <= 3'd1;
        else if (age != 3'd7) age <= age + 3'd1;
      end
    end

    assign data_window = (LAT == 1) ? mem_en[gi] : (!mem_en[gi] && age == 3'(LAT - 1));
    assign mem_rdata[gi] = data_window ? mem[mem_addr[gi][5:2]] : 32'hBAD0_BAD0;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          keep_if [2];
  bit          keep_d  [2];
  logic [31:0] exp_drd [2];
  int          nv_if   [2];
  int          nv_d    [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int k, output exp_t e);
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  // A store completion is expected to leave d_rdata at the last load value.
  task automatic push(input int k, input bit is_d, input bit we, input logic [31:0] data, input int at);
    exp_t e;
    e.is_d = is_d;
    e.at   = at;
    if (is_d && we) begin
      e.data = exp_drd[k];
    end else begin
      e.data = data;
      if (is_d) exp_drd[k] = data;
    end
    qpush(k, e);
  endtask

  // Advance to the next falling edge, score any completion, and apply the
  // requester rule (drop req in its valid cycle unless asked to keep it).
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (if_valid[k] || d_valid[k]) begin
        if (if_valid[k]) nv_if[k]++;
        if (d_valid[k]) nv_d[k]++;
        check($sformatf("dut%0d_expected_completion", k), 32'(qsize(k) != 0), 32'd1);
        if (qsize(k) != 0) begin
          qpop(k, e);
          $display("dut%0d cycle %0d: %s valid rdata=%h (expected %s %h at cycle %0d)",
                   k, cyc, d_valid[k] ? "d" : "if", d_valid[k] ? d_rdata[k] : if_rdata[k],
                   e.is_d ? "d" : "if", e.data, e.at);
          check($sformatf("dut%0d_port", k), {30'd0, if_valid[k], d_valid[k]}, e.is_d ? 32'd1 : 32'd2);
          check($sformatf("dut%0d_cycle", k), 32'(cyc), 32'(e.at));
          check($sformatf("dut%0d_rdata", k), e.is_d ? d_rdata[k] : if_rdata[k], e.data);
        end
        if (if_valid[k] && !keep_if[k]) if_req[k] = 1'b0;
        if (d_valid[k] && !keep_d[k]) d_req[k] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int k, input int budget);
    for (int i = 0; i < budget && qsize(k) != 0; i++) step();
    check($sformatf("dut%0d_drain", k), 32'(qsize(k)), 32'd0);
  endtask

  task automatic check_zero_outputs(input int k, input string tag);
    check($sformatf("%s_dut%0d_ctrl", tag, k),
          {27'd0, if_valid[k], d_valid[k], mem_en[k], mem_we[k], busy[k]}, 32'd0);
    check($sformatf("%s_dut%0d_if_rdata", tag, k), if_rdata[k], 32'd0);
    check($sformatf("%s_dut%0d_d_rdata", tag, k), d_rdata[k], 32'd0);
    check($sformatf("%s_dut%0d_mem_addr", tag, k), mem_addr[k], 32'd0);
    check($sformatf("%s_dut%0d_mem_wdata", tag, k), mem_wdata[k], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int base_if;
    int base_d;
    bit rr;
    bit is_d;

`ifdef ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      keep_if[k] = 1'b0; keep_d[k] = 1'b0; exp_drd[k] = '0;
      nv_if[k] = 0; nv_d[k] = 0;
    end

    // Reset state
    step(); step();
    check_zero_outputs(0, "reset");
    check_zero_outputs(1, "reset");
    rst[0] = 1'b1; rst[1] = 1'b1;
    step();

    // 1: single fetch, MEM_LAT=1
    c = cyc;
    if_addr[0] = 32'h0040_0000; if_req[0] = 1'b1;
    push(0, 1'b0, 1'b0, 32'h0000_0013, c + 2);
    step();
    check("t1_mem_en_issue", 32'(mem_en[0]), 32'd1);
    check("t1_mem_addr", mem_addr[0], 32'h0040_0000);
    check("t1_mem_we", 32'(mem_we[0]), 32'd0);
    check("t1_busy_wait", 32'(busy[0]), 32'd1);
    step();
    check("t1_mem_en_single", 32'(mem_en[0]), 32'd0);
    check("t1_busy_done", 32'(busy[0]), 32'd0);
    step();
    check("t1_if_valid_one_cycle", 32'(if_valid[0]), 32'd0);
    check("t1_if_rdata_hold", if_rdata[0], 32'h0000_0013);
    drain(0, 4);

    // 2: store, MEM_LAT=3, then load it back
    c = cyc;
    d_we[1] = 1'b1; d_addr[1] = 32'h1001_0004; d_wdata[1] = 32'hDEAD_BEEF; d_req[1] = 1'b1;
    push(1, 1'b1, 1'b1, 32'd0, c + 4);
    step();
    check("t2_mem_en_issue", 32'(mem_en[1]), 32'd1);
    check("t2_mem_we", 32'(mem_we[1]), 32'd1);
    check("t2_mem_addr", mem_addr[1], 32'h1001_0004);
    check("t2_mem_wdata", mem_wdata[1], 32'hDEAD_BEEF);
    check("t2_busy_wait", 32'(busy[1]), 32'd1);
    d_addr[1] = 32'h1001_0FF0; d_wdata[1] = 32'h0BAD_F00D;
    step();
    check("t2_mem_en_low", 32'(mem_en[1]), 32'd0);
    check("t2_we_held", 32'(mem_we[1]), 32'd1);
    check("t2_addr_latched", mem_addr[1], 32'h1001_0004);
    check("t2_wdata_latched", mem_wdata[1], 32'hDEAD_BEEF);
    step(); step();
    check("t2_we_cleared", 32'(mem_we[1]), 32'd0);
    check("t2_busy_done", 32'(busy[1]), 32'd0);
    step();
    check("t2_d_rdata_unchanged", d_rdata[1], 32'd0);
    drain(1, 4);
    c = cyc;
    d_we[1] = 1'b0; d_addr[1] = 32'h1001_0004; d_req[1] = 1'b1;
    push(1, 1'b1, 1'b0, 32'hDEAD_BEEF, c + 4);
    drain(1, 10);

    // 3: simultaneous requests on instance 0
    base_if = nv_if[0]; base_d = nv_d[0];
    c = cyc;
    if_addr[0] = 32'h0040_0004; if_req[0] = 1'b1;
    d_we[0] = 1'b0; d_addr[0] = 32'h1001_0008; d_req[0] = 1'b1;
    push(0, 1'b1, 1'b0, init_word(2), c + 2);
    push(0, 1'b0, 1'b0, init_word(1), c + 4);
    step();
    check("t3_data_first", mem_addr[0], 32'h1001_0008);
    step();
    step();
    check("t3_fetch_issue_en", 32'(mem_en[0]), 32'd1);
    check("t3_fetch_issue_addr", mem_addr[0], 32'h0040_0004);
    drain(0, 6);
    step(); step();
    check("t3_if_valid_count", 32'(nv_if[0] - base_if), 32'd1);
    check("t3_d_valid_count", 32'(nv_d[0] - base_d), 32'd1);

    // 6: fetch held high, back-to-back every 2 cycles
    base_if = nv_if[0];
    keep_if[0] = 1'b1;
    c = cyc;
    if_addr[0] = 32'h0040_0000; if_req[0] = 1'b1;
    push(0, 1'b0, 1'b0, init_word(0), c + 2);
    for (int n = 0; n < 4; n++) begin
      step(); step();
      if (n < 3) begin
        if_addr[0] = 32'h0040_0000 + 32'((n + 1) * 4);
        push(0, 1'b0, 1'b0, init_word(n + 1), c + 2 * n + 4);
      end else begin
        if_req[0] = 1'b0; keep_if[0] = 1'b0;
      end
    end
    step(); step();
    check("t6_if_valid_count", 32'(nv_if[0] - base_if), 32'd4);
    check("t6_drain", 32'(qsize(0)), 32'd0);

    // Reset instance 0 (clears rdata), then 4: both requests held
    rst[0] = 1'b0;
    #1;
    check_zero_outputs(0, "rst0");
    exp_drd[0] = '0;
    step();
    rst[0] = 1'b1;
    step();
    keep_if[0] = 1'b1; keep_d[0] = 1'b1;
    if_addr[0] = 32'h0040_0004; d_addr[0] = 32'h1001_0008; d_we[0] = 1'b0;
    c = cyc;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      is_d = rr ? (n % 2 == 0) : 1'b1;
      push(0, is_d, 1'b0, is_d ? init_word(2) : init_word(1), c + 2 + 2 * n);
    end
    for (int n = 0; n < 4; n++) begin
      step(); step();
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0; keep_if[0] = 1'b0; keep_d[0] = 1'b0;
    step(); step();
    check("t4_drain", 32'(qsize(0)), 32'd0);

    // 5: reset one cycle after issue, MEM_LAT=3
    base_if = nv_if[1]; base_d = nv_d[1];
    d_we[1] = 1'b0; d_addr[1] = 32'h1001_0008; d_req[1] = 1'b1;
    step();
    check("t5_issued", 32'(mem_en[1]), 32'd1);
    step();
    rst[1] = 1'b0;
    #1;
    check_zero_outputs(1, "t5_async_reset");
    d_req[1] = 1'b0; exp_drd[1] = '0;
    step();
    rst[1] = 1'b1;
    repeat (8) step();
    check("t5_no_valid", 32'((nv_if[1] - base_if) + (nv_d[1] - base_d)), 32'd0);
    check("t5_idle", {30'd0, busy[1], mem_en[1]}, 32'd0);

    check("final_q0_empty", 32'(qsize(0)), 32'd0);
    check("final_q1_empty", 32'(qsize(1)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
